// File: rtl/mul_div_32_pkg.sv
// Shared encodings and constants for the iterative 32-bit multiply/divide unit.
package mdu_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/mul_div_32_if.sv
// Start/busy/done request bus between the datapath controller and the multiply/divide unit.
interface mul_div_32_if;
  import mdu_pkg::*;

  logic        start;
  op_e         op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  modport master (output start, op, a, b,
                  input  busy, done, hi, lo, div_by_zero);
  modport slave  (input  start, op, a, b,
                  output busy, done, hi, lo, div_by_zero);
endinterface

// File: rtl/mul_div_32_abs_neg.sv
// Conditional two's-complement negate, shared by input magnitude and result sign fix-up.
module abs_neg_32 (
  input  logic [31:0] val_i,
  input  logic        neg_i,
  output logic [31:0] res_o
);
  assign res_o = neg_i ? (~val_i + 32'd1) : val_i;
endmodule

// File: rtl/mul_div_32.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 shift-add or restoring-divide steps, result in HI/LO.
module mul_div_32
  import mdu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  mul_div_32_if.slave  bus
);

  state_e             state_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic               sign_a_q;
  logic [31:0]        a_raw_q;
  logic [31:0]        dvsr_q;
  logic [63:0]        acc_q;
  logic [63:0]        acc_d;
  logic [CNT_W-1:0]   count_q;
  logic               busy_q, done_q, dbz_q;
  logic [31:0]        hi_q, lo_q;

  logic               in_signed;
  logic [31:0]        mag_a, mag_b;
  logic [32:0]        add_x, add_y, sum;
  logic               add_cin;
  logic [31:0]        quot_fix, rem_fix;
  logic [31:0]        prod_lo_n, prod_hi_n;
  logic [31:0]        res_hi, res_lo;
  logic               dvsr_zero;

  assign in_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign dvsr_zero = (dvsr_q == 32'd0);

  abs_neg_32 u_abs_a (.val_i(bus.a), .neg_i(in_signed & bus.a[31]), .res_o(mag_a));
  abs_neg_32 u_abs_b (.val_i(bus.b), .neg_i(in_signed & bus.b[31]), .res_o(mag_b));

  // One 33-bit adder serves both loops; divide subtracts via ~y + 1.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    add_x   = {1'b0, acc_q[63:32]};
    add_y   = acc_q[0] ? {1'b0, dvsr_q} : 33'd0;
    add_cin = 1'b0;
    if (is_div_q) begin
      add_x   = {1'b0, acc_q[62:31]};
      add_y   = ~{1'b0, dvsr_q};
      add_cin = 1'b1;
    end
    sum = add_x + add_y + 33'(add_cin);
    if (!is_div_q) begin
      acc_d = {sum, acc_q[31:1]};
    end else if (acc_q[63] || !sum[32]) begin
      // A set bit shifted out of rem means the trial value exceeds any 32-bit divisor.
      acc_d = {sum[31:0], acc_q[30:0], 1'b1};
    end else begin
      acc_d = {acc_q[62:0], 1'b0};
    end
  end

  abs_neg_32 u_fix_q (.val_i(acc_d[31:0]),  .neg_i(neg_res_q), .res_o(quot_fix));
  abs_neg_32 u_fix_r (.val_i(acc_d[63:32]), .neg_i(sign_a_q),  .res_o(rem_fix));

  assign prod_lo_n = ~acc_d[31:0] + 32'd1;
  assign prod_hi_n = ~acc_d[63:32] + {31'd0, (acc_d[31:0] == 32'd0)};

  always_comb begin
    res_hi = acc_d[63:32];
    res_lo = acc_d[31:0];
    if (is_div_q && dvsr_zero) begin
      res_hi = a_raw_q;
      res_lo = 32'hFFFF_FFFF;
    end else if (is_div_q) begin
      res_hi = rem_fix;
      res_lo = quot_fix;
    end else if (neg_res_q) begin
      res_hi = prod_hi_n;
      res_lo = prod_lo_n;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: all state here is plain flops (no memory array), so everything is cleared on reset.
    if (rst) begin
      state_q   <= ST_IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      sign_a_q  <= 1'b0;
      a_raw_q   <= '0;
      dvsr_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            is_div_q  <= bus.op[1];
            neg_res_q <= in_signed & (bus.a[31] ^ bus.b[31]);
            sign_a_q  <= in_signed & bus.a[31];
            a_raw_q   <= bus.a;
            dvsr_q    <= bus.op[1] ? mag_b : mag_a;
            acc_q     <= {32'd0, (bus.op[1] ? mag_a : mag_b)};
            count_q   <= CNT_W'(ITER - 1);
            busy_q    <= 1'b1;
            dbz_q     <= 1'b0;
            state_q   <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          if (count_q == '0) begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            dbz_q   <= is_div_q & dvsr_zero;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule
